// File: rtl/instruction_fetch_unit_if.sv
// Fetch-stage bus bundle: instruction memory port, redirect input and IF/ID handshake.
// The master modport is the fetch unit; the slave side is memory, decode and hazard logic.
interface instruction_fetch_unit_if #(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [31:0]   imem_addr;
    logic [31:0]   imem_dout;
    logic          redirect_valid;
    logic [31:0]   redirect_pc;
    logic          id_ready;
    logic          if_valid;
    logic [31:0]   if_inst;
    logic [31:0]   if_pc;
    logic [CW-1:0] fifo_count;

    modport master (
        output imem_addr, if_valid, if_inst, if_pc, fifo_count,
        input  imem_dout, redirect_valid, redirect_pc, id_ready
    );

    modport slave (
        input  imem_addr, if_valid, if_inst, if_pc, fifo_count,
        output imem_dout, redirect_valid, redirect_pc, id_ready
    );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the PC, reads the combinational instruction memory and
// buffers {pc, inst} pairs in a prefetch FIFO that feeds the IF/ID register.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    instruction_fetch_unit_if.master  bus
);
    localparam int          PW  = $clog2(DEPTH);
    localparam int          CW  = PW + 1;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [31:0]   pc;
    logic [31:0]   fifo_pc   [DEPTH];
    logic [31:0]   fifo_inst [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic          head_valid;
    logic          pop;
    logic          push;

    // A redirect suppresses both the pop and the push of its cycle.
    assign head_valid = (count != '0);
    assign pop        = head_valid & bus.id_ready & ~bus.redirect_valid;
    assign push       = ~bus.redirect_valid & ((count < CW'(DEPTH)) | pop);

    assign bus.imem_addr  = pc;
    assign bus.if_valid   = head_valid;
    assign bus.if_inst    = head_valid ? fifo_inst[rd_ptr] : NOP;
    assign bus.if_pc      = head_valid ? fifo_pc[rd_ptr]   : 32'h0;
    assign bus.fifo_count = count;

    always_ff @(posedge clk) begin
        if (reset) begin
            pc     <= RESET_PC;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (bus.redirect_valid) begin
            pc     <= {bus.redirect_pc[31:2], 2'b00};
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                pc     <= pc + 32'd4;
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Storage needs no reset: entries are only visible while count says they are occupied.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_pc[wr_ptr]   <= pc;
            fifo_inst[wr_ptr] <= bus.imem_dout;
        end
    end
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: directed scenarios plus random traffic
// compared against a queue-based model of the fetch FIFO.
module tb_instruction_fetch_unit;
    localparam int          DEPTH    = 4;
    localparam int          CW       = $clog2(DEPTH) + 1;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] mem_xor;

    int checks = 0;
    int fails  = 0;

    logic [63:0] m_q[$];
    logic [31:0] m_pc;

    always #5 clk = ~clk;

    instruction_fetch_unit_if #(.DEPTH(DEPTH)) bus ();

    instruction_fetch_unit #(
        .RESET_PC (RESET_PC),
        .DEPTH    (DEPTH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Memory word is a simple function of the address so every fetch is traceable.
    assign bus.imem_dout = bus.imem_addr ^ mem_xor;

    function automatic logic exp_valid();
        return m_q.size() != 0;
    endfunction

    function automatic logic [31:0] exp_pc();
        return (m_q.size() != 0) ? m_q[0][63:32] : 32'h0;
    endfunction

    function automatic logic [31:0] exp_inst();
        return (m_q.size() != 0) ? m_q[0][31:0] : NOP;
    endfunction

    function automatic logic [CW-1:0] exp_count();
        return CW'(m_q.size());
    endfunction

    // Drive one cycle of inputs, advance the model at the edge, return at the next negedge.
    task automatic cycle(input logic rst, input logic rv, input logic [31:0] rpc, input logic rdy);
        logic do_pop;
        logic do_push;
        reset              = rst;
        bus.redirect_valid = rv;
        bus.redirect_pc    = rpc;
        bus.id_ready       = rdy;
        @(posedge clk);
        if (rst) begin
            m_q.delete();
            m_pc = RESET_PC;
        end else if (rv) begin
            m_q.delete();
            m_pc = rpc & 32'hFFFF_FFFC;
        end else begin
            do_pop  = (m_q.size() != 0) && rdy;
            do_push = (m_q.size() < DEPTH) || do_pop;
            if (do_pop) void'(m_q.pop_front());
            if (do_push) begin
                m_q.push_back({m_pc, m_pc ^ mem_xor});
                m_pc = m_pc + 32'd4;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        cycle(1'b1, 1'b0, 32'h0, 1'b0);
        cycle(1'b1, 1'b0, 32'h0, 1'b1);
        checks++;
        if (bus.if_valid !== 1'b0) begin
            fails++; $display("[TB] FAIL reset_valid: got %b expected 0", bus.if_valid);
        end
        checks++;
        if (bus.if_inst !== NOP) begin
            fails++; $display("[TB] FAIL reset_inst: got %h expected %h", bus.if_inst, NOP);
        end
        checks++;
        if (bus.if_pc !== 32'h0) begin
            fails++; $display("[TB] FAIL reset_pc: got %h expected 0", bus.if_pc);
        end
        checks++;
        if (bus.fifo_count !== CW'(0)) begin
            fails++; $display("[TB] FAIL reset_count: got %0d expected 0", bus.fifo_count);
        end
        checks++;
        if (bus.imem_addr !== RESET_PC) begin
            fails++; $display("[TB] FAIL reset_addr: got %h expected %h", bus.imem_addr, RESET_PC);
        end
    endtask

    task automatic test_stream();
        test_reset();
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 1'b0, 32'h0, 1'b1);
            checks++;
            if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'(4 * i)) begin
                fails++;
                $display("[TB] FAIL stream_pc step %0d: got valid=%b pc=%h expected valid=1 pc=%h",
                         i, bus.if_valid, bus.if_pc, 32'(4 * i));
            end
            checks++;
            if (bus.fifo_count !== CW'(1) || bus.if_inst !== 32'(4 * i)) begin
                fails++;
                $display("[TB] FAIL stream_count step %0d: got count=%0d inst=%h expected count=1 inst=%h",
                         i, bus.fifo_count, bus.if_inst, 32'(4 * i));
            end
        end
    endtask

    task automatic test_stall_and_full();
        int exp_n;
        test_reset();
        for (int i = 0; i < 6; i++) begin
            cycle(1'b0, 1'b0, 32'h0, 1'b0);
            exp_n = (i + 1 < DEPTH) ? i + 1 : DEPTH;
            checks++;
            if (bus.fifo_count !== CW'(exp_n) || bus.imem_addr !== 32'(4 * exp_n)) begin
                fails++;
                $display("[TB] FAIL stall_fill step %0d: got count=%0d addr=%h expected count=%0d addr=%h",
                         i, bus.fifo_count, bus.imem_addr, exp_n, 32'(4 * exp_n));
            end
        end
        // Full queue draining with simultaneous refill: count holds at DEPTH.
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'(4 * i)) begin
                fails++;
                $display("[TB] FAIL stall_release step %0d: got valid=%b pc=%h expected valid=1 pc=%h",
                         i, bus.if_valid, bus.if_pc, 32'(4 * i));
            end
            cycle(1'b0, 1'b0, 32'h0, 1'b1);
            checks++;
            if (bus.fifo_count !== CW'(DEPTH) || bus.imem_addr !== 32'(16 + 4 * (i + 1))) begin
                fails++;
                $display("[TB] FAIL full_pushpop step %0d: got count=%0d addr=%h expected count=%0d addr=%h",
                         i, bus.fifo_count, bus.imem_addr, DEPTH, 32'(16 + 4 * (i + 1)));
            end
        end
    endtask

    task automatic test_redirect();
        test_reset();
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 32'h0, 1'b0);
        cycle(1'b0, 1'b1, 32'h0000_0103, 1'b0);
        checks++;
        if (bus.if_valid !== 1'b0 || bus.fifo_count !== CW'(0) || bus.imem_addr !== 32'h100) begin
            fails++;
            $display("[TB] FAIL redirect_flush: got valid=%b count=%0d addr=%h expected valid=0 count=0 addr=00000100",
                     bus.if_valid, bus.fifo_count, bus.imem_addr);
        end
        cycle(1'b0, 1'b0, 32'h0, 1'b0);
        checks++;
        if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'h100 || bus.if_inst !== (32'h100 ^ mem_xor)) begin
            fails++;
            $display("[TB] FAIL redirect_target: got valid=%b pc=%h inst=%h expected valid=1 pc=00000100 inst=%h",
                     bus.if_valid, bus.if_pc, bus.if_inst, 32'h100 ^ mem_xor);
        end
    endtask

    task automatic test_back_to_back();
        logic saw_40;
        saw_40 = 1'b0;
        test_reset();
        cycle(1'b0, 1'b0, 32'h0, 1'b1);
        cycle(1'b0, 1'b1, 32'h40, 1'b1);
        if (bus.if_valid === 1'b1 && bus.if_pc === 32'h40) saw_40 = 1'b1;
        cycle(1'b0, 1'b1, 32'h80, 1'b1);
        checks++;
        if (bus.if_valid !== 1'b0 || bus.imem_addr !== 32'h80) begin
            fails++;
            $display("[TB] FAIL b2b_flush: got valid=%b addr=%h expected valid=0 addr=00000080",
                     bus.if_valid, bus.imem_addr);
        end
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b0, 32'h0, 1'b1);
            if (bus.if_pc === 32'h40) saw_40 = 1'b1;
            checks++;
            if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'(32'h80 + 4 * i)) begin
                fails++;
                $display("[TB] FAIL b2b_stream step %0d: got valid=%b pc=%h expected valid=1 pc=%h",
                         i, bus.if_valid, bus.if_pc, 32'(32'h80 + 4 * i));
            end
        end
        checks++;
        if (saw_40 !== 1'b0) begin
            fails++; $display("[TB] FAIL b2b_no_40: got 0x40 entry output, expected none");
        end
    endtask

    task automatic test_mid_reset();
        test_reset();
        cycle(1'b0, 1'b1, 32'h200, 1'b0);
        cycle(1'b0, 1'b0, 32'h0, 1'b0);
        cycle(1'b0, 1'b0, 32'h0, 1'b0);
        checks++;
        if (bus.fifo_count !== CW'(2) || bus.if_pc !== 32'h200) begin
            fails++;
            $display("[TB] FAIL midreset_setup: got count=%0d pc=%h expected count=2 pc=00000200",
                     bus.fifo_count, bus.if_pc);
        end
        cycle(1'b1, 1'b0, 32'h0, 1'b0);
        checks++;
        if (bus.if_valid !== 1'b0 || bus.fifo_count !== CW'(0) || bus.imem_addr !== RESET_PC
            || bus.if_inst !== NOP) begin
            fails++;
            $display("[TB] FAIL midreset_clear: got valid=%b count=%0d addr=%h inst=%h expected 0/0/%h/%h",
                     bus.if_valid, bus.fifo_count, bus.imem_addr, bus.if_inst, RESET_PC, NOP);
        end
        cycle(1'b0, 1'b0, 32'h0, 1'b1);
        checks++;
        if (bus.if_valid !== 1'b1 || bus.if_pc !== RESET_PC) begin
            fails++;
            $display("[TB] FAIL midreset_restart: got valid=%b pc=%h expected valid=1 pc=%h",
                     bus.if_valid, bus.if_pc, RESET_PC);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] want;
        cycle(1'b0, 1'b1, 32'hFFFF_FFF9, 1'b1);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 1'b0, 32'h0, 1'b1);
            want = 32'hFFFF_FFF8 + 32'(4 * i);
            checks++;
            if (bus.if_valid !== 1'b1 || bus.if_pc !== want) begin
                fails++;
                $display("[TB] FAIL wrap_pc step %0d: got valid=%b pc=%h expected valid=1 pc=%h",
                         i, bus.if_valid, bus.if_pc, want);
            end
        end
    endtask

    task automatic test_random();
        logic        rst;
        logic        rv;
        logic [31:0] rpc;
        logic        rdy;
        mem_xor = $urandom;
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 63) == 0);
            rv  = ($urandom_range(0, 7) == 0);
            rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
            rdy = ($urandom_range(0, 1) == 1);
            cycle(rst, rv, rpc, rdy);
            checks++;
            if (bus.if_valid !== exp_valid() || bus.if_pc !== exp_pc() || bus.if_inst !== exp_inst()
                || bus.fifo_count !== exp_count() || bus.imem_addr !== m_pc) begin
                fails++;
                $display("[TB] FAIL random step %0d: got v=%b pc=%h inst=%h cnt=%0d addr=%h expected v=%b pc=%h inst=%h cnt=%0d addr=%h",
                         i, bus.if_valid, bus.if_pc, bus.if_inst, bus.fifo_count, bus.imem_addr,
                         exp_valid(), exp_pc(), exp_inst(), exp_count(), m_pc);
            end
        end
    endtask

    initial begin
        reset              = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        bus.id_ready       = 1'b0;
        mem_xor            = 32'h0;
        m_pc               = RESET_PC;
        @(negedge clk);
        test_reset();
        test_stream();
        test_stall_and_full();
        test_redirect();
        test_back_to_back();
        test_mid_reset();
        test_wrap();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
